// File: rtl/cb_param_counter.sv
// cb_param_counter: parametrised up/down counter with modulus wrap, synchronous
// clear/load, terminal-count and cascade outputs, and a sticky overflow flag.
// Optional build macro CB_PARAM_COUNTER_SAT_EN selects saturating mode: the count
// holds at its limit instead of wrapping, and CEO stays low.
module cb_param_counter #(
  parameter int     WIDTH   = 16,
  parameter longint MODULUS = 0
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic             EN,
  input  logic             UP,
  input  logic             SCLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             OVF
);

  // Highest reachable count; the full binary range when MODULUS is 0.
  localparam logic [WIDTH-1:0] MAX = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == '0);
  assign w_tc      = UP ? w_at_max : w_at_zero;

  // Load value is clamped to MAX; with a full-range modulus every D is legal,
  // so no comparison is built at all.
  generate
    if (MODULUS == 0) begin : g_ld_full
      assign w_ld_val = D;
    end else begin : g_ld_clamp
      assign w_ld_val = (D > MAX) ? MAX : D;
    end
  endgenerate

  // Next-state selection with priority clear > load > count > hold.
  always_comb begin
    w_q_next   = r_q;
    w_ovf_next = r_ovf;
    if (SCLR) begin
      w_q_next   = '0;
      w_ovf_next = 1'b0;
    end else if (LD) begin
      w_q_next = w_ld_val;
    end else if (EN) begin
      if (UP) begin
        if (w_at_max) begin
`ifdef CB_PARAM_COUNTER_SAT_EN
          w_q_next = MAX;
`else
          w_q_next = '0;
`endif
          w_ovf_next = 1'b1;
        end else begin
          // r_q < MAX here, so the increment cannot leave the WIDTH range.
          w_q_next = r_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
`ifdef CB_PARAM_COUNTER_SAT_EN
          w_q_next = '0;
`else
          w_q_next = MAX;
`endif
          w_ovf_next = 1'b1;
        end else begin
          w_q_next = r_q - WIDTH'(1);
        end
      end
    end
  end

  // Counter and sticky flag registers, cleared directly by CDN.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign Q   = r_q;
  assign OVF = r_ovf;
  assign TC  = w_tc;

`ifdef CB_PARAM_COUNTER_SAT_EN
  // A saturating stage never rolls over, so it never hands a carry/borrow upward.
  assign CEO = 1'b0;
`else
  assign CEO = w_tc & EN;
`endif

endmodule
